// File: rtl/seg_display_mux_if.sv
// Display bus for seg_display_mux: packed BCD/decimal-point request in,
// multiplexed active-low segment/anode drive and frame pulse out.
interface seg_display_mux_if;
  logic [11:0] i_bcd;
  logic [2:0]  i_dp;
  logic [7:0]  o_seg;
  logic [2:0]  o_an;
  logic        o_frame;

  modport master (output i_bcd, i_dp, input o_seg, o_an, o_frame);
  modport slave  (input i_bcd, i_dp, output o_seg, o_an, o_frame);
endinterface

// File: rtl/seg_display_mux.sv
// 3-digit multiplexed active-low seven-segment driver with per-frame input snapshot.
// Optional leading-zero blanking of digits 2/1 when SEG_LEADING_ZERO_BLANK_EN is defined.
module seg_display_mux #(
  parameter int CLK_HZ       = 100_000_000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 100
) (
  input logic               i_clk,
  input logic               i_reset,
  seg_display_mux_if.slave  bus
);

  localparam int DIV = CLK_HZ / SCAN_HZ;
  localparam int CW  = $clog2(DIV);
  localparam logic [CW-1:0] LAST      = CW'(DIV - 1);
  localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

  logic [CW-1:0] cnt_reg;
  logic [1:0]    idx_reg;
  logic [11:0]   snap_bcd_reg;
  logic [2:0]    snap_dp_reg;
  logic [7:0]    seg_reg;
  logic [2:0]    an_reg;
  logic          frame_reg;

  logic          tick;
  logic          wrap;
  logic [7:0]    seg_next;
  logic [2:0]    an_next;
  logic [6:0]    glyph [3];
  logic [2:0]    blank;

  assign tick = (cnt_reg == LAST);
  assign wrap = tick && (idx_reg == 2'd2);

  // Active-low {g,f,e,d,c,b,a}; non-decimal nibbles show a dash.
  function automatic logic [6:0] encode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = 7'h40;
      4'd1:    pat = 7'h79;
      4'd2:    pat = 7'h24;
      4'd3:    pat = 7'h30;
      4'd4:    pat = 7'h19;
      4'd5:    pat = 7'h12;
      4'd6:    pat = 7'h02;
      4'd7:    pat = 7'h78;
      4'd8:    pat = 7'h00;
      4'd9:    pat = 7'h10;
      default: pat = 7'h3F;
    endcase
    return pat;
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_glyph
      assign glyph[gi] = encode(snap_bcd_reg[4*gi +: 4]);
    end
  endgenerate

`ifdef SEG_LEADING_ZERO_BLANK_EN
  assign blank[2] = (snap_bcd_reg[11:8] == 4'd0);
  assign blank[1] = (snap_bcd_reg[11:8] == 4'd0) && (snap_bcd_reg[7:4] == 4'd0);
  assign blank[0] = 1'b0;
`else
  assign blank = 3'b000;
`endif

  always_comb begin
    seg_next = 8'hFF;
    an_next  = 3'b111;
    for (int k = 0; k < 3; k++) begin
      if (idx_reg == 2'(k)) begin
        an_next[k] = 1'b0;
        seg_next   = {~snap_dp_reg[k], (blank[k] ? 7'h7F : glyph[k])};
      end
    end
    // Anti-ghosting: anodes stay off while segments settle on the new digit.
    if (cnt_reg < BLANK_LIM) an_next = 3'b111;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cnt_reg      <= '0;
      idx_reg      <= 2'd0;
      snap_bcd_reg <= 12'd0;
      snap_dp_reg  <= 3'd0;
      seg_reg      <= 8'hFF;
      an_reg       <= 3'b111;
      frame_reg    <= 1'b0;
    end else begin
      cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
      if (tick) idx_reg <= (idx_reg == 2'd2) ? 2'd0 : idx_reg + 2'd1;
      if (wrap) begin
        snap_bcd_reg <= bus.i_bcd;
        snap_dp_reg  <= bus.i_dp;
      end
      frame_reg <= wrap;
      seg_reg   <= seg_next;
      an_reg    <= an_next;
    end
  end

  assign bus.o_seg   = seg_reg;
  assign bus.o_an    = an_reg;
  assign bus.o_frame = frame_reg;

endmodule

// File: tb/tb_seg_display_mux.sv
// Scoreboard bench for seg_display_mux (DIV=4, BLANK_CYCLES=1); expectations
// follow SEG_LEADING_ZERO_BLANK_EN when it is defined.
module tb_seg_display_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg_display_mux_if bus();

  seg_display_mux #(
    .CLK_HZ      (16),
    .SCAN_HZ     (4),
    .BLANK_CYCLES(1)
  ) dut (
    .i_clk  (clk),
    .i_reset(rst),
    .bus    (bus)
  );

  int n_cmp   = 0;
  int n_bad   = 0;
  int rst_cnt = 0;
  logic [23:0] exp_q [$];

  // Directed vectors; expected segments packed as {digit2, digit1, digit0}.
  logic [11:0] v_bcd [9] = '{12'h159, 12'h059, 12'h100, 12'h0A0, 12'h007,
                             12'h000, 12'h842, 12'hFFF, 12'h376};
  logic [2:0]  v_dp  [9] = '{3'b010, 3'b000, 3'b000, 3'b000, 3'b000,
                             3'b100, 3'b001, 3'b111, 3'b000};
  int          v_dly [9] = '{0, 0, 5, 0, 3, 0, 7, 0, 11};
`ifdef SEG_LEADING_ZERO_BLANK_EN
  logic [23:0] v_exp [9] = '{24'hF91290, 24'hFF9290, 24'hF9C0C0, 24'hFFBFC0, 24'hFFFFF8,
                             24'h7FFFC0, 24'h809924, 24'h3F3F3F, 24'hB0F882};
  logic [23:0] rst_exp = 24'hFFFFC0;
`else
  logic [23:0] v_exp [9] = '{24'hF91290, 24'hC09290, 24'hF9C0C0, 24'hC0BFC0, 24'hC0C0F8,
                             24'h40C0C0, 24'h809924, 24'h3F3F3F, 24'hB0F882};
  logic [23:0] rst_exp = 24'hC0C0C0;
`endif
  logic [2:0] an_seq [12] = '{3'b111, 3'b110, 3'b110, 3'b110,
                              3'b111, 3'b101, 3'b101, 3'b101,
                              3'b111, 3'b011, 3'b011, 3'b011};

  always @(posedge rst) rst_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic wait_frame();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (bus.o_frame === 1'b1) found = 1'b1;
    end
    check("frame_seen", 32'(found), 32'd1);
  endtask

  // Runs from a reset release: checks the anode scan and the reset snapshot.
  task automatic reset_frame_check(input string tag);
    logic early;
    early = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("%s_an%0d", tag, c), 32'(bus.o_an), 32'(an_seq[c]));
      if (c % 4 == 1)
        check($sformatf("%s_seg_d%0d", tag, c / 4), 32'(bus.o_seg), 32'(rst_exp[8*(c/4) +: 8]));
      if (c < 11 && bus.o_frame !== 1'b0) early = 1'b1;
    end
    check({tag, "_no_early_frame"}, 32'(early), 32'd0);
    check({tag, "_first_frame"}, 32'(bus.o_frame), 32'd1);
  endtask

  // Monitor: every o_frame starts a 12-cycle frame; collect lit digits and score it.
  initial begin : monitor
    logic [7:0]  segs [3];
    logic [2:0]  got;
    logic        extra;
    logic        bad_an;
    logic [23:0] e;
    int          r0;
    int          last_r;
    time         last_t;
    logic        have_last;
    have_last = 1'b0;
    last_r    = 0;
    last_t    = 0;
    forever begin
      @(negedge clk);
      while (bus.o_frame === 1'b1) begin
        if (have_last && last_r == rst_cnt)
          check("frame_period", 32'(($time - last_t) / 10), 32'd12);
        have_last = 1'b1;
        last_t    = $time;
        last_r    = rst_cnt;
        r0        = rst_cnt;
        got       = 3'b000;
        extra     = 1'b0;
        bad_an    = 1'b0;
        for (int k = 0; k < 3; k++) segs[k] = 8'h00;
        for (int c = 1; c <= 12; c++) begin
          @(negedge clk);
          if (c < 12 && bus.o_frame !== 1'b0) extra = 1'b1;
          case (bus.o_an)
            3'b111: ;
            3'b110: begin segs[0] = bus.o_seg; got[0] = 1'b1; end
            3'b101: begin segs[1] = bus.o_seg; got[1] = 1'b1; end
            3'b011: begin segs[2] = bus.o_seg; got[2] = 1'b1; end
            default: bad_an = 1'b1;
          endcase
        end
        if (rst_cnt == r0) begin
          check("frame_width", 32'(extra), 32'd0);
          check("an_onehot", 32'(bad_an), 32'd0);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("digits_lit", 32'(got), 32'd7);
            for (int k = 0; k < 3; k++)
              check($sformatf("frame_seg_d%0d", k), 32'(segs[k]), 32'(e[8*k +: 8]));
          end
        end
      end
    end
  end

  initial begin : stimulus
    bus.i_bcd = 12'h000;
    bus.i_dp  = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous assertion between edges must act at once.
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("async_rst_an", 32'(bus.o_an), 32'h7);
    check("async_rst_seg", 32'(bus.o_seg), 32'hFF);
    check("async_rst_frame", 32'(bus.o_frame), 32'h0);

    bus.i_bcd = v_bcd[0];
    bus.i_dp  = v_dp[0];
    exp_q.push_back(v_exp[0]);
    @(negedge clk);
    rst = 1'b0;
    reset_frame_check("init");

    for (int v = 1; v < 9; v++) begin
      repeat (v_dly[v]) @(negedge clk);
      bus.i_bcd = v_bcd[v];
      bus.i_dp  = v_dp[v];
      exp_q.push_back(v_exp[v]);
      wait_frame();
    end

    // Let the last vector's frame be scored, then reset just before a wrap edge.
    wait_frame();
    bus.i_bcd = 12'h999;
    bus.i_dp  = 3'b000;
    repeat (11) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_an", 32'(bus.o_an), 32'h7);
    check("midrst_seg", 32'(bus.o_seg), 32'hFF);
    @(negedge clk);
    check("midrst_no_frame", 32'(bus.o_frame), 32'h0);
    rst = 1'b0;
    exp_q.push_back(24'h909090);
    reset_frame_check("midrst");

    repeat (14) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin : watchdog
    #50000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/seg_display_mux.md
# seg_display_mux

Downstream consumer of the BCD time counters: takes a 3-digit packed BCD value and drives the board's multiplexed, active-low 3-digit seven-segment display. It scans one digit at a time at a parameterised rate, inserts anti-ghosting blank time between digits, and snapshots the input once per frame so a count changing mid-scan never shows a torn value.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency.
- `SCAN_HZ`, 1000: digit-switch rate. `DIV = CLK_HZ/SCAN_HZ` (integer division). Constraint: `DIV >= 2`.
- `BLANK_CYCLES`, 100: cycles at the start of each digit slot with all anodes off. Constraint: `BLANK_CYCLES < DIV`.

Ports:
- `i_clk` in 1: single clock.
- `i_reset` in 1: asynchronous, active-high reset.
- `i_bcd` in 12: packed BCD; `[3:0]` is digit 0 (least significant), `[7:4]` is digit 1, `[11:8]` is digit 2.
- `i_dp` in 3: decimal point request per digit, active-high.
- `o_seg` out 8: `{dp,g,f,e,d,c,b,a}`, active-low.
- `o_an` out 3: digit enables, active-low. `o_an[k]` drives digit k.
- `o_frame` out 1: one-cycle pulse, high in the cycle the snapshot holds newly loaded data.

## Operation
- **Prescaler `cnt`:** counts 0..DIV-1 and wraps to 0. `tick` = (`cnt` == DIV-1).
- **Digit index `idx`:** advances 0→1→2→0 on the edge where `tick` is high. Value 3 is never reached.
- **Snapshot register (15 bits: `i_bcd` and `i_dp`):**
  - Loads on the edge where `tick` is high and `idx` == 2, i.e. the same edge `idx` wraps to 0.
  - It is not updated at any other time. `i_bcd` may change freely in between.
- **`o_frame`:** registered. Set to 1 on the snapshot-load edge and cleared on the next edge.
- **Segment encode** (active-low, bit 7 = dp off = 1):
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90.
  - Nibbles A–F display a dash: BF.
  - dp: bit 7 is cleared when the snapshot `dp[idx]` = 1.
- **Anode encode:**
  - `o_an` = all high except bit `idx` low.
  - Exception: while `cnt` < `BLANK_CYCLES`, `o_an` = 3'b111 (blank window).
  - During the blank window `o_seg` still carries the new digit's pattern.
- **Reset** (asynchronous, takes effect immediately):
  - `cnt`=0, `idx`=0, snapshot=0.
  - `o_an`=3'b111, `o_seg`=8'hFF, `o_frame`=0.
  - Reset asserted mid-frame abandons the frame; no partial snapshot is taken.
  - After release, the first frame displays the reset snapshot (000, or 0 with blanking enabled). Live data appears after the first wrap.

## Timing
- `o_seg`, `o_an` are registered functions of (`idx`, `cnt`, snapshot) sampled one clock earlier.
- Output latency is 1 cycle from an internal state change.
- Digit slot = DIV cycles:
  - BLANK_CYCLES cycles with anodes off, then DIV − BLANK_CYCLES cycles with anode k low.
  - Slot boundaries on `o_an` lag the `idx` change by 1 cycle.
- Frame = 3·DIV cycles. `o_frame` period = 3·DIV cycles, exactly one cycle high.
- Input-to-display latency: up to 3·DIV + 1 cycles, plus the blank window.
- At most one `o_an` bit is low at any time. No glitch is permitted: all outputs come straight from flops.

## Configuration
- Macro **`SEG_LEADING_ZERO_BLANK_EN`**.
- **Defined:**
  - Digit 2 is blanked (segments a–g off) when its snapshot nibble is 0.
  - Digit 1 is blanked when digits 2 and 1 are both 0.
  - Digit 0 is never blanked.
  - dp still follows `i_dp` on blanked digits.
  - Anodes scan unchanged.
- **Undefined:** all digits always show their nibble. This is the default.

## Test plan
Bench uses CLK_HZ=16, SCAN_HZ=4 (DIV=4), BLANK_CYCLES=1.
1. **Reset.** Assert `i_reset` asynchronously mid-cycle → `o_an`=111, `o_seg`=FF, `o_frame`=0 immediately. After release, `o_an` sequence per 4-cycle slot is 111,110,110,110, then 111,101,…, then 111,011,….
2. **Snapshot and encode.** `i_bcd`=12'h159, `i_dp`=3'b010 held → after first `o_frame`:
   - digit 0 `o_seg`=90
   - digit 1 `o_seg`=12 (dp on)
   - digit 2 `o_seg`=F9
   - `o_frame` period = 12 cycles.
3. **Tearing.** Change `i_bcd` from 12'h059 to 12'h100 while `idx`=1 → the current frame still shows 0,5,9. The next frame shows 1,0,0.
4. **Invalid BCD.** `i_bcd`=12'h0A0 → digit 1 `o_seg`=BF. Digits 0 and 2 show C0 (without macro).
5. **Leading-zero blanking** (`SEG_LEADING_ZERO_BLANK_EN` defined): `i_bcd`=12'h007 →
   - digit 2 and digit 1 `o_seg`=FF, digit 0 = F8.
   - `i_bcd`=12'h000 → digit 0 = C0.
   - `i_bcd`=12'h000, `i_dp`=3'b100 → digit 2 = 7F.
6. **Reset mid-frame.** Pulse `i_reset` while `idx`=2, `cnt`=3 (edge pending) → no `o_frame` pulse. The snapshot stays 0 until the next full wrap.
